// File: rtl/pe_result_serializer_if.sv
// rtl/pe_result_serializer_if.sv - vector-in / lane-stream-out handshake bundle
interface pe_result_serializer_if #(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    logic                                 in_valid;
    logic                                 in_ready;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] in_data;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [DATA_WIDTH-1:0]                out_data;
    logic [IDX_W-1:0]                     out_idx;
    logic                                 out_last;

    // master: the surrounding environment (array upstream, consumer downstream)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    // slave: the serializer itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/pe_result_serializer.sv
// rtl/pe_result_serializer.sv - shadows a packed lane vector and streams it lane by lane
module pe_result_serializer #(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    pe_result_serializer_if.slave    bus,
    output logic                     busy
);
    localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_SIZE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                                state_q, state_d;
    logic [IDX_W-1:0]                      cnt_q, cnt_d;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] shadow_q, shadow_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d  = SEND;
                    cnt_d    = '0;
                    shadow_d = bus.in_data;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is decoded from registered state only; stale shadow data is masked in IDLE.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == SEND);
    assign busy          = (state_q == SEND);
    assign bus.out_data  = (state_q == SEND) ? shadow_q[cnt_q] : '0;
    assign bus.out_idx   = cnt_q;
    assign bus.out_last  = (state_q == SEND) && (cnt_q == LAST_IDX);
endmodule

// File: doc/pe_result_serializer.md
# pe_result_serializer

Collects one packed result vector from a processing array (ARRAY_SIZE lanes of DATA_WIDTH bits) and emits it as a lane-by-lane stream on a single DATA_WIDTH-bit output with valid/ready handshaking. It sits downstream of the processing array and performs the gather side of the array's broadcast: wide parallel results in, one narrow sequential stream out. A shadow register frees the array to produce its next result while the current vector is streamed.

## Interface

- ARRAY_SIZE, 4, number of lanes per input vector (>= 1)
- DATA_WIDTH, 8, bits per lane
- IDX_W, derived as max(1, $clog2(ARRAY_SIZE)), lane index width (not overridable)

- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data holds a valid vector
- in_ready  output  1  block can accept a vector this cycle
- in_data  input  [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]  packed lane results; lane i = in_data[i]
- out_valid  output  1  out_data/out_idx/out_last are valid
- out_ready  input  1  downstream accepts the current beat
- out_data  output  DATA_WIDTH  current lane value
- out_idx  output  IDX_W  lane number of the current beat
- out_last  output  1  current beat is lane ARRAY_SIZE-1
- busy  output  1  a vector is held (state SEND)

## Operation

- Two states: IDLE, SEND. Reset state IDLE.
- IDLE: in_ready=1, out_valid=0, busy=0. On in_valid=1, capture all of in_data into the shadow register, set lane counter to 0, go to SEND.
- SEND: in_ready=0, out_valid=1, busy=1; out_data = shadow[counter], out_idx = counter, out_last = (counter == ARRAY_SIZE-1).
- Beat transfer = out_valid & out_ready at a rising edge.
  - Transfer, not last: counter increments by 1, stay in SEND.
  - Transfer, last: counter returns to 0, go to IDLE.
  - No transfer: counter, shadow and all outputs hold (no change while stalled).
- Lanes are always emitted in ascending order 0..ARRAY_SIZE-1; no lane is skipped or repeated.
- in_data is sampled only on the accepting edge; later changes to in_data have no effect on the vector being streamed.
- in_valid while in_ready=0 is ignored; the upstream holds its vector until accepted.
- ARRAY_SIZE=1: every beat has out_idx=0 and out_last=1; the counter never increments.
- in_ready, out_valid, busy and out_last are decoded from registered state and counter only; no combinational path from any input to any output.

## Timing

- Reset (rst=1 at an edge): state IDLE, counter 0, shadow cleared to 0. Outputs after that edge: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0 (forced 0 while not in SEND), busy=0.
- Reset mid-stream: the vector in progress is discarded with no further beats; the next vector starts from lane 0.
- Latency: vector accepted at edge N, lane 0 valid in the cycle after edge N.
- Throughput without backpressure: ARRAY_SIZE beats on consecutive cycles, then one IDLE cycle; ARRAY_SIZE+1 cycles per vector.
- After the last-beat transfer edge, in_ready=1 in the following cycle.

## Test plan

- Basic: ARRAY_SIZE=4, DATA_WIDTH=8, out_ready=1, in_data lanes {3..0}={0x44,0x33,0x22,0x11} -> out_data 0x11,0x22,0x33,0x44 on four consecutive cycles starting one cycle after acceptance, out_idx 0..3, out_last only on 0x44, in_ready=1 the cycle after.
- Backpressure: same vector, out_ready low for 3 cycles while lane 1 is presented -> out_data stays 0x22 and out_idx stays 1 throughout; the stream then resumes with 0x33, 0x44. No loss or duplication.
- Input held off: in_valid=1 with a new vector {0xDD,0xCC,0xBB,0xAA} while busy -> ignored until in_ready=1. The new vector is then accepted and emitted 0xAA..0xDD. Changing in_data during SEND does not alter the lanes being streamed.
- Back-to-back: in_valid held high with two vectors -> 10 cycles total, each vector in lane order, one in_ready cycle between them.
- Reset mid-stream: rst=1 after lane 1 transfers -> all outputs take their reset values on the next edge. The next accepted vector starts at out_idx=0.
- Degenerate: ARRAY_SIZE=1, in_data=0x5A -> one beat with out_data=0x5A, out_idx=0, out_last=1, then IDLE.
